// File: rtl/gamepad_pkg.sv
// Shared gamepad definitions: button bit positions, d-pad range and the SNES-only mask.
package gamepad_pkg;

  localparam int NUM_BTNS = 12;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_X      = 8;
  localparam int BTN_Y      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int DPAD_LO = BTN_UP;
  localparam int DPAD_HI = BTN_RIGHT;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

  localparam btn_vec_t SNES_MASK = 12'hF00;

  // An NES pad has no X/Y/L/R, so those lines are forced low.
  function automatic btn_vec_t mask_buttons(input btn_vec_t raw, input logic is_snes);
    return is_snes ? raw : (raw & ~SNES_MASK);
  endfunction

endpackage

// File: rtl/gamepad_event_decoder_if.sv
// Bundle between the gamepad receiver/consumers (master) and the event decoder (slave).
interface gamepad_event_decoder_if;
  import gamepad_pkg::*;

  logic     controller_latch;
  logic     is_snes;
  btn_vec_t buttons_in;
  btn_vec_t held;
  btn_vec_t pressed;
  btn_vec_t released;
  logic     frame_tick;

  modport master (
    output controller_latch, is_snes, buttons_in,
    input  held, pressed, released, frame_tick
  );

  modport slave (
    input  controller_latch, is_snes, buttons_in,
    output held, pressed, released, frame_tick
  );

endinterface

// File: rtl/gamepad_repeat_ctr.sv
// Per-direction auto-repeat frame counter; built only when GAMEPAD_AUTOREPEAT_EN is defined.
`ifdef GAMEPAD_AUTOREPEAT_EN
module gamepad_repeat_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       capture,
  input  logic       now,
  input  logic       prev,
  input  logic [7:0] delay_frames,
  input  logic [7:0] period_frames,
  output logic       repeat_pulse
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (capture) begin
      if (now && !prev) begin
        cnt <= delay_frames;
      end else if (now && prev) begin
        if (cnt == 8'd1) begin
          cnt <= period_frames;
        end else if (cnt > 8'd1) begin
          cnt <= cnt - 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

  // Requiring now keeps a release on the expiry frame from also repeating.
  assign repeat_pulse = capture && now && prev && (cnt == 8'd1);

endmodule
`endif

// File: rtl/gamepad_event_decoder.sv
// Per-frame button event stage: held levels plus one-cycle pressed/released pulses.
// Optional d-pad auto-repeat is enabled by defining GAMEPAD_AUTOREPEAT_EN.
module gamepad_event_decoder
  import gamepad_pkg::*;
#(
  parameter int REPEAT_DELAY_FRAMES  = 20,
  parameter int REPEAT_PERIOD_FRAMES = 6
) (
  input logic                    clk_50,
  input logic                    reset,
  gamepad_event_decoder_if.slave bus
);

  logic     latch_d;
  logic     capture;
  btn_vec_t m;
  btn_vec_t rep;
  btn_vec_t held_q;
  btn_vec_t pressed_q;
  btn_vec_t released_q;
  logic     tick_q;

  assign capture = bus.controller_latch && !latch_d;
  assign m       = mask_buttons(bus.buttons_in, bus.is_snes);

`ifdef GAMEPAD_AUTOREPEAT_EN
  logic [DPAD_HI-DPAD_LO:0] rep_dpad;

  for (genvar i = DPAD_LO; i <= DPAD_HI; i++) begin : g_rep
    gamepad_repeat_ctr u_ctr (
      .clk           (clk_50),
      .reset         (reset),
      .capture       (capture),
      .now           (m[i]),
      .prev          (held_q[i]),
      .delay_frames  (8'(REPEAT_DELAY_FRAMES)),
      .period_frames (8'(REPEAT_PERIOD_FRAMES)),
      .repeat_pulse  (rep_dpad[i-DPAD_LO])
    );
  end

  assign rep = btn_vec_t'(rep_dpad) << DPAD_LO;
`else
  logic [15:0] unused_repeat_params;
  assign unused_repeat_params = {8'(REPEAT_DELAY_FRAMES), 8'(REPEAT_PERIOD_FRAMES)};
  assign rep = '0;
`endif

  // latch_d resets high so a latch already asserted at reset release is not a frame.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      latch_d    <= 1'b1;
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      latch_d <= bus.controller_latch;
      if (capture) begin
        held_q     <= m;
        pressed_q  <= (m & ~held_q) | rep;
        released_q <= ~m & held_q;
        tick_q     <= 1'b1;
      end else begin
        pressed_q  <= '0;
        released_q <= '0;
        tick_q     <= 1'b0;
      end
    end
  end

  assign bus.held       = held_q;
  assign bus.pressed    = pressed_q;
  assign bus.released   = released_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_gamepad_event_decoder.sv
// Directed self-checking bench for gamepad_event_decoder (DELAY=3, PERIOD=2).
`timescale 1ns/1ps
module tb_gamepad_event_decoder;

`ifdef GAMEPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic clk_50 = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  gamepad_event_decoder_if bus ();

  gamepad_event_decoder #(
    .REPEAT_DELAY_FRAMES  (3),
    .REPEAT_PERIOD_FRAMES (2)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check_output(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk_50);
    #1;
  endtask

  // Raise the latch with new buttons; outputs are valid after the following edge.
  task automatic apply_stimulus(input logic [11:0] buttons);
    bus.buttons_in       = buttons;
    bus.controller_latch = 1'b1;
    tick_cycle();
  endtask

  task automatic end_frame();
    bus.controller_latch = 1'b0;
    tick_cycle();
  endtask

  initial begin
    logic [11:0] exp_p;

    reset                = 1'b1;
    bus.controller_latch = 1'b1;
    bus.is_snes          = 1'b0;
    bus.buttons_in       = 12'h0FF;
    repeat (3) tick_cycle();
    check_output("rst_held", bus.held, 12'h000);
    check_output("rst_pressed", bus.pressed, 12'h000);
    check_output("rst_released", bus.released, 12'h000);
    check_output("rst_tick", {11'b0, bus.frame_tick}, 12'h000);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_cycle();
      check_output("rst_latch_high_tick", {11'b0, bus.frame_tick}, 12'h000);
      check_output("rst_latch_high_held", bus.held, 12'h000);
    end
    end_frame();

    $display("[TB] NES masking");
    bus.is_snes = 1'b0;
    apply_stimulus(12'hF01);
    check_output("nes_held", bus.held, 12'h001);
    check_output("nes_pressed", bus.pressed, 12'h001);
    check_output("nes_tick", {11'b0, bus.frame_tick}, 12'h001);
    check_output("nes_released", bus.released, 12'h000);
    end_frame();
    check_output("nes_pressed_width", bus.pressed, 12'h000);
    check_output("nes_tick_width", {11'b0, bus.frame_tick}, 12'h000);
    check_output("nes_held_stable", bus.held, 12'h001);
    apply_stimulus(12'h000);
    check_output("nes_release", bus.released, 12'h001);
    check_output("nes_release_held", bus.held, 12'h000);
    end_frame();

    $display("[TB] SNES press/hold/release");
    bus.is_snes = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(12'h300);
      check_output("snes_pressed", bus.pressed, (k == 1) ? 12'h300 : 12'h000);
      check_output("snes_held", bus.held, 12'h300);
      end_frame();
    end
    apply_stimulus(12'h000);
    check_output("snes_released", bus.released, 12'h300);
    check_output("snes_rel_pressed", bus.pressed, 12'h000);
    end_frame();

    $display("[TB] SNES to NES switch while held");
    apply_stimulus(12'hF00);
    check_output("switch_pressed", bus.pressed, 12'hF00);
    end_frame();
    bus.is_snes = 1'b0;
    apply_stimulus(12'hF00);
    check_output("switch_released", bus.released, 12'hF00);
    check_output("switch_held", bus.held, 12'h000);
    end_frame();

    $display("[TB] auto-repeat on up");
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(12'h010);
      exp_p = (k == 1 || (AUTOREPEAT && (k == 4 || k == 6 || k == 8))) ? 12'h010 : 12'h000;
      check_output($sformatf("repeat_cap%0d", k), bus.pressed, exp_p);
      end_frame();
      check_output("repeat_width", bus.pressed, 12'h000);
    end
    apply_stimulus(12'h000);
    check_output("repeat_released", bus.released, 12'h010);
    end_frame();

    $display("[TB] release vs repeat expiry");
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(12'h010);
      check_output($sformatf("rvr_cap%0d", k), bus.pressed, (k == 1) ? 12'h010 : 12'h000);
      end_frame();
    end
    apply_stimulus(12'h000);
    check_output("rvr_no_press", bus.pressed, 12'h000);
    check_output("rvr_released", bus.released, 12'h010);
    end_frame();

    $display("[TB] back-to-back latch");
    apply_stimulus(12'h002);
    check_output("b2b_pressed1", bus.pressed, 12'h002);
    check_output("b2b_tick1", {11'b0, bus.frame_tick}, 12'h001);
    end_frame();
    check_output("b2b_tick_gap", {11'b0, bus.frame_tick}, 12'h000);
    apply_stimulus(12'h004);
    check_output("b2b_pressed2", bus.pressed, 12'h004);
    check_output("b2b_released2", bus.released, 12'h002);
    check_output("b2b_tick2", {11'b0, bus.frame_tick}, 12'h001);
    check_output("b2b_held", bus.held, 12'h004);
    end_frame();

    $display("[TB] reset mid-repeat");
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(12'h010);
      end_frame();
    end
    reset = 1'b1;
    tick_cycle();
    check_output("midrst_held", bus.held, 12'h000);
    reset = 1'b0;
    tick_cycle();
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(12'h010);
      exp_p = (k == 1 || (AUTOREPEAT && k == 4)) ? 12'h010 : 12'h000;
      check_output($sformatf("midrst_cap%0d", k), bus.pressed, exp_p);
      end_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
